// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1:4 round-robin / steered dispatch front-end.
//   NCH      number of output channels
//   SEL_W    width of a channel index (target select, rr pointer)
//   RR_WRAP  last rr pointer value before wrapping back to channel 0
//   sel_t    channel index type
//   ch_state_t  per-channel buffer occupancy
//   rr_next()   round-robin successor of a channel index
// ---------------------------------------------------------------------------
package demux_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t RR_WRAP = 2'd3;

   typedef enum logic {
      CH_EMPTY = 1'b0,
      CH_FULL  = 1'b1
   } ch_state_t;

   // Successor of a round-robin pointer, wrapping RR_WRAP back to channel 0.
   function automatic sel_t rr_next(input sel_t ptr);
      sel_t nxt;
      if (ptr == RR_WRAP) begin
         nxt = 2'd0;
      end else begin
         nxt = ptr + 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// ---------------------------------------------------------------------------
// demux_chan_buf
// One-entry register slice for a single output channel, plus a saturating
// count of the words loaded into it.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (empties slice, clears data/count)
//   flush      synchronous clear of occupancy; data and count are kept
//   load       write in_data this cycle (takes priority over drain)
//   drain      consumer takes the held word this cycle
//   in_data    word to load
//   out_valid  slice holds a word
//   out_data   held word (keeps its last value after a drain)
//   count      saturating number of words loaded
// ---------------------------------------------------------------------------
module demux_chan_buf
   import demux_pkg::*;
#(
   parameter int DW    = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic             drain,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   output logic [DW-1:0]    out_data,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   ch_state_t        state_r;
   ch_state_t        state_s;
   logic [DW-1:0]    data_r;
   logic [CNT_W-1:0] count_r;
   logic             load_ok_s;

   // A load is only honoured when no flush is present in the same cycle.
   assign load_ok_s = load & ~flush;

   // Occupancy state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= CH_EMPTY;
      end else begin
         state_r <= state_s;
      end
   end

   // Occupancy next state: flush wins, then load (refill keeps FULL), then drain.
   always_comb begin
      state_s = state_r;
      case (state_r)
         CH_EMPTY: begin
            if (load_ok_s) begin
               state_s = CH_FULL;
            end else begin
               state_s = CH_EMPTY;
            end
         end
         CH_FULL: begin
            if (flush) begin
               state_s = CH_EMPTY;
            end else if (load_ok_s) begin
               state_s = CH_FULL;
            end else if (drain) begin
               state_s = CH_EMPTY;
            end else begin
               state_s = CH_FULL;
            end
         end
         default: begin
            state_s = CH_EMPTY;
         end
      endcase
   end

   // Held word; only written on an accepted load, so it survives drains and flushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= '0;
      end else if (load_ok_s) begin
         data_r <= in_data;
      end else begin
         data_r <= data_r;
      end
   end

   // Saturating count of loads; flush deliberately leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
      end else if (load_ok_s && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign out_valid = (state_r == CH_FULL);
   assign out_data  = data_r;
   assign count     = count_r;

endmodule

// File: rtl/demux_rr_dispatch_1_4.sv
// ---------------------------------------------------------------------------
// demux_rr_dispatch_1_4
// Flow-controlled 1:4 dispatch. Each input word goes to one channel, chosen
// either round-robin (mode=0) or by in_sel (mode=1). Each channel holds one
// registered word until its consumer takes it; a full channel can be refilled
// in the same cycle it drains. The head word blocks on its target channel.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   flush      synchronous clear of all channel buffers and the rr pointer
//   mode       0 = round-robin, 1 = steered by in_sel
//   in_sel     steered target channel
//   in_valid, in_data, in_ready   input word handshake
//   out_valid, out_data, out_ready   per-channel handshake (channel i at [i*DW +: DW])
//   rr_ptr     current round-robin target
//   ch_count   per-channel saturating accepted-word counts (channel i at [i*CNT_W +: CNT_W])
// ---------------------------------------------------------------------------
module demux_rr_dispatch_1_4
   import demux_pkg::*;
#(
   parameter int DW    = 8,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   output logic                 in_ready,
   output logic [NCH-1:0]       out_valid,
   output logic [NCH*DW-1:0]    out_data,
   input  logic [NCH-1:0]       out_ready,
   output logic [SEL_W-1:0]     rr_ptr,
   output logic [NCH*CNT_W-1:0] ch_count
);

   sel_t           rr_ptr_r;
   sel_t           rr_ptr_s;
   sel_t           tgt_s;
   logic           ready_s;
   logic           accept_s;
   logic [NCH-1:0] load_s;
   logic [NCH-1:0] drain_s;

   assign tgt_s = mode ? in_sel : rr_ptr_r;

   // Target can take a word if empty or being emptied this cycle; held low in reset and flush.
   assign ready_s  = ~rst & ~flush & (~out_valid[tgt_s] | out_ready[tgt_s]);
   assign in_ready = ready_s;
   assign accept_s = in_valid & ready_s;

   // Round-robin pointer next value: only round-robin accepts move it.
   always_comb begin
      rr_ptr_s = rr_ptr_r;
      if (flush) begin
         rr_ptr_s = 2'd0;
      end else if (accept_s && !mode) begin
         rr_ptr_s = rr_next(rr_ptr_r);
      end else begin
         rr_ptr_s = rr_ptr_r;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r <= 2'd0;
      end else begin
         rr_ptr_r <= rr_ptr_s;
      end
   end

   assign rr_ptr = rr_ptr_r;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign load_s[i]  = accept_s & (tgt_s == sel_t'(i));
      assign drain_s[i] = out_valid[i] & out_ready[i];

      demux_chan_buf #(
         .DW    (DW),
         .CNT_W (CNT_W)
      ) u_buf (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .load      (load_s[i]),
         .drain     (drain_s[i]),
         .in_data   (in_data),
         .out_valid (out_valid[i]),
         .out_data  (out_data[i*DW +: DW]),
         .count     (ch_count[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_demux_rr_dispatch_1_4.sv
module tb_demux_rr_dispatch_1_4;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        mode;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [3:0]  out_valid;
   logic [31:0] out_data;
   logic [3:0]  out_ready;
   logic [1:0]  rr_ptr;
   logic [31:0] ch_count;

   int n_vec = 0;
   int n_err = 0;

   // reference model: per-channel contents and counts, rr pointer as an integer
   bit       m_valid [4];
   bit [7:0] m_data  [4];
   int       m_cnt   [4];
   int       m_rr;

   demux_rr_dispatch_1_4 #(.DW(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .mode      (mode),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .rr_ptr    (rr_ptr),
      .ch_count  (ch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_data[i]  = 8'h00;
         m_cnt[i]   = 0;
      end
      m_rr = 0;
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0]  ev;
      logic [31:0] ed;
      logic [31:0] ec;
      for (int i = 0; i < 4; i++) begin
         ev[i]         = m_valid[i];
         ed[i*8 +: 8]  = m_data[i];
         ec[i*8 +: 8]  = 8'(m_cnt[i]);
      end
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      check({tag, ".out_data"},  64'(out_data),  64'(ed));
      check({tag, ".rr_ptr"},    64'(rr_ptr),    64'(m_rr));
      check({tag, ".ch_count"},  64'(ch_count),  64'(ec));
   endtask

   // One clock cycle with the inputs already applied (called at a falling edge).
   task automatic cycle(input string tag);
      int  t;
      bit  er;
      bit  acc;
      #1;
      t  = mode ? int'(in_sel) : m_rr;
      er = !flush && (!m_valid[t] || out_ready[t]);
      check({tag, ".in_ready"}, 64'(in_ready), 64'(er));
      acc = in_valid && er;
      @(posedge clk);
      if (flush) begin
         for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
         m_rr = 0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (m_valid[i] && out_ready[i]) m_valid[i] = 1'b0;
         if (acc) begin
            m_valid[t] = 1'b1;
            m_data[t]  = in_data;
            if (m_cnt[t] < 255) m_cnt[t]++;
            if (!mode) m_rr = (m_rr + 1) % 4;
         end
      end
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] t1 [5];
      t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44; t1[4] = 8'h55;

      rst = 1'b1; flush = 1'b0; mode = 1'b0; in_sel = 2'd0;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 4'b0000;
      model_reset();
      #12;
      check("reset.in_ready", 64'(in_ready), 64'd0);
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // 1: round-robin stream, all consumers ready
      out_ready = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_data = t1[k];
         cycle("t1");
      end
      check("t1.ch0_last", 64'(out_data[7:0]), 64'h55);
      check("t1.rr_after", 64'(rr_ptr), 64'd1);
      in_valid = 1'b0;
      cycle("t1.idle");

      // 2: ch1 blocked, then pass-through refill
      flush = 1'b1; cycle("t2.flush"); flush = 1'b0;
      out_ready = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = t1[k];
         cycle("t2.fill");
      end
      in_data = 8'h66;
      cycle("t2.blocked");
      check("t2.blocked_ready", 64'(in_ready), 64'd0);
      out_ready = 4'b1111;
      cycle("t2.refill");
      check("t2.ch1_valid", 64'(out_valid[1]), 64'd1);
      check("t2.ch1_data", 64'(out_data[15:8]), 64'h66);
      in_valid = 1'b0;
      cycle("t2.idle");

      // 3: steered to ch2, rr pointer frozen
      mode = 1'b1; in_sel = 2'd2;
      in_valid = 1'b1; in_data = 8'hA5; cycle("t3.a");
      check("t3.ch2_a", 64'(out_data[23:16]), 64'hA5);
      in_data = 8'h5A; cycle("t3.b");
      check("t3.ch2_b", 64'(out_data[23:16]), 64'h5A);
      in_valid = 1'b0; cycle("t3.idle");

      // 4: fill all, flush one cycle
      mode = 1'b0; out_ready = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 8'(8'hC0 + k);
         cycle("t4.fill");
      end
      in_valid = 1'b1; flush = 1'b1;
      cycle("t4.flush");
      check("t4.valid_clear", 64'(out_valid), 64'd0);
      flush = 1'b0; in_valid = 1'b0;
      cycle("t4.idle");

      // 5: saturate ch0 count
      mode = 1'b1; in_sel = 2'd0; out_ready = 4'b1111; in_valid = 1'b1;
      for (int k = 0; k < 260; k++) begin
         in_data = 8'($urandom);
         cycle("t5");
      end
      check("t5.sat", 64'(ch_count[7:0]), 64'd255);
      in_valid = 1'b0; cycle("t5.idle");

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         mode      = 1'($urandom);
         in_sel    = 2'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = 4'($urandom);
         flush     = ($urandom_range(0, 19) == 0);
         cycle("rnd");
      end
      flush = 1'b0;

      // 6: asynchronous reset with ch3 full, mid-stream
      mode = 1'b1; in_sel = 2'd3; out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h77;
      cycle("t6.fill");
      check("t6.ch3_full", 64'(out_valid[3]), 64'd1);
      mode = 1'b0; in_data = 8'h78;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("t6.async_valid", 64'(out_valid), 64'd0);
      check("t6.async_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("t6.held_ready", 64'(in_ready), 64'd0);
      check_outputs("t6.held");
      @(negedge clk);
      rst = 1'b0;
      out_ready = 4'b1111;
      cycle("t6.resume");
      in_valid = 1'b0;
      cycle("t6.idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
